// File: rtl/data_memory_unit_if.sv
// Request, CDB-result and output-byte channels of the data memory stage.
// The master side issues requests and sinks results; the slave side is the memory unit.
interface data_memory_unit_if #(
    parameter int DATA_W   = 32,
    parameter int RSV_ID_W = 4,
    parameter int INSTR_W  = 6
);
    localparam int CDB_W = RSV_ID_W + DATA_W;

    logic                i_valid;
    logic [INSTR_W-1:0]  i_opcode;
    logic [RSV_ID_W-1:0] i_rsv_id;
    logic [DATA_W-1:0]   i_address;
    logic [DATA_W-1:0]   i_data;
    logic                i_ready;

    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready;

    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output i_valid, i_opcode, i_rsv_id, i_address, i_data, o_cdb_ready, out_ready,
        input  i_ready, o_cdb, o_cdb_valid, out_data, out_valid
    );

    modport slave (
        input  i_valid, i_opcode, i_rsv_id, i_address, i_data, o_cdb_ready, out_ready,
        output i_ready, o_cdb, o_cdb_valid, out_data, out_valid
    );
endinterface

// File: rtl/data_memory_unit.sv
// Data memory stage: word RAM for loads/stores, output byte register, and a
// credit-protected result FIFO that returns load data to the CDB in order.
module data_memory_unit #(
    parameter int MEM_DEPTH_W  = 12,
    parameter int RESULT_DEPTH = 4,
    parameter int DATA_W       = 32,
    parameter int RSV_ID_W     = 4,
    parameter int INSTR_W      = 6
) (
    input  logic                 clk,
    input  logic                 nrst,
    data_memory_unit_if.slave    bus,
    output logic                 err_opcode,
    output logic                 err_addr
);
    localparam int PTR_W   = $clog2(RESULT_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_LOAD    = INSTR_W'(1);
    localparam logic [INSTR_W-1:0] I_LOADB   = INSTR_W'(2);
    localparam logic [INSTR_W-1:0] I_STORE   = INSTR_W'(3);
    localparam logic [INSTR_W-1:0] I_STOREB  = INSTR_W'(4);
    localparam logic [INSTR_W-1:0] I_STORER  = INSTR_W'(5);
    localparam logic [INSTR_W-1:0] I_OUTPUT  = INSTR_W'(6);

    typedef enum logic [1:0] {CLS_LOAD, CLS_STORE, CLS_OUTPUT, CLS_BAD} op_class_t;

    op_class_t               op_class;
    logic                    ready;
    logic                    accept;
    logic                    load_acc;
    logic                    store_acc;
    logic                    out_acc;
    logic                    bad_acc;
    logic [MEM_DEPTH_W-1:0]  index;
    logic                    addr_oor;

    logic [DATA_W-1:0]       mem [2**MEM_DEPTH_W];
    logic [DATA_W-1:0]       rdata;
    logic [DATA_W-1:0]       load_word;
    logic                    inflight;
    logic                    inflight_oor;
    logic [RSV_ID_W-1:0]     inflight_tag;

    logic [ENTRY_W-1:0]      fifo_mem [RESULT_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        credit_used;
    logic                    cdb_valid;
    logic                    push;
    logic                    pop;

    logic                    out_valid_q;
    logic [7:0]              out_data_q;

    assign index       = bus.i_address[MEM_DEPTH_W-1:0];
    assign addr_oor    = |bus.i_address[DATA_W-1:MEM_DEPTH_W];
    assign credit_used = count + CNT_W'(inflight);

    always_comb begin
        op_class = CLS_BAD;
        case (bus.i_opcode)
            I_LOAD, I_LOADB:             op_class = CLS_LOAD;
            I_STORE, I_STOREB, I_STORER: op_class = CLS_STORE;
            I_OUTPUT:                    op_class = CLS_OUTPUT;
            default:                     op_class = CLS_BAD;
        endcase
    end

    // A slot is reserved for a read still in the RAM so the push never overflows.
    always_comb begin
        ready = 1'b1;
        case (op_class)
            CLS_LOAD:   ready = credit_used < CNT_W'(RESULT_DEPTH);
            CLS_OUTPUT: ready = !out_valid_q || bus.out_ready;
            default:    ready = 1'b1;
        endcase
    end

    assign accept    = bus.i_valid && ready;
    assign load_acc  = accept && (op_class == CLS_LOAD);
    assign store_acc = accept && (op_class == CLS_STORE);
    assign out_acc   = accept && (op_class == CLS_OUTPUT);
    assign bad_acc   = accept && (op_class == CLS_BAD);

    assign cdb_valid = (count != '0);
    assign push      = inflight;
    assign pop       = cdb_valid && bus.o_cdb_ready;
    assign load_word = inflight_oor ? '0 : rdata;

    always_ff @(posedge clk) begin
        if (store_acc && !addr_oor)
            mem[index] <= bus.i_data;
        if (load_acc)
            rdata <= mem[index];
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail] <= {inflight_tag, load_word};
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            inflight     <= 1'b0;
            inflight_oor <= 1'b0;
            inflight_tag <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_opcode   <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            inflight <= load_acc;
            if (load_acc) begin
                inflight_tag <= bus.i_rsv_id;
                inflight_oor <= addr_oor;
            end
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (out_acc) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.i_data[7:0];
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bad_acc)
                err_opcode <= 1'b1;
            if ((load_acc || store_acc) && addr_oor)
                err_addr <= 1'b1;
        end
    end

    assign bus.i_ready     = ready;
    assign bus.o_cdb_valid = cdb_valid;
    assign bus.o_cdb       = cdb_valid ? fifo_mem[head] : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Backing data-memory stage directly downstream of the memory functional unit. It accepts one committed store, one dispatched load or one OUTPUT request per cycle and applies it to an internal synchronous word RAM or the output byte stream. Load results return to the common data bus (CDB) through a credit-protected result FIFO. Stores and OUTPUT produce no CDB traffic.

## Interface
- MEM_DEPTH_W, 12: log2 of RAM depth in words.
- RESULT_DEPTH, 4: result FIFO entries (power of two, ≥2).
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset; synchronous, active-high.
- i_valid  in  1  request valid.
- i_opcode  in  INSTR_W  I_LOAD, I_LOADB, I_STORE, I_STOREB, I_STORER or I_OUTPUT.
- i_rsv_id  in  RSV_ID_W  ROB tag of the request.
- i_address  in  DATA_W  word address, already computed upstream.
- i_data  in  DATA_W  store data; OUTPUT uses bits [7:0].
- i_ready  out  1  request accepted when i_valid && i_ready.
- o_cdb  out  CDB_W  {rsv_id, load data}.
- o_cdb_valid  out  1  result valid.
- o_cdb_ready  in  1  CDB grant.
- out_data  out  8  output byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  output sink ready.
- err_opcode  out  1  sticky: an unsupported opcode was accepted.
- err_addr  out  1  sticky: an access had i_address[DATA_W-1:MEM_DEPTH_W] ≠ 0.

## Operation
- Opcode classes:
  - Load = I_LOAD, I_LOADB.
  - Store = I_STORE, I_STOREB, I_STORER.
  - Output = I_OUTPUT.
  - Byte variants behave as their word form here.
- Any other opcode is accepted (i_ready=1), dropped, and sets err_opcode.
- Index = i_address[MEM_DEPTH_W-1:0].
- i_ready is a function of i_opcode and internal state only; it never depends on i_valid:
  - Store: 1.
  - Output: !out_valid || out_ready.
  - Load: (fifo_count + inflight) < RESULT_DEPTH. inflight is the 1-bit register marking a RAM read under way.
- Store accept:
  - In-range: RAM[index] ← i_data at the accepting edge.
  - Out-of-range: write suppressed, err_addr set.
- Load accept:
  - RAM read issued in the accept cycle; inflight set with tag and range flag.
  - Next cycle: rdata, or 0 if out-of-range, is pushed to the FIFO as {tag, data}.
  - Out-of-range load also sets err_addr.
- RAM is read-first on an address collision within one cycle. Sequential store-then-load in the next cycle returns the stored value; one request per cycle means no same-cycle write/read.
- Output accept: out_data ← i_data[7:0], out_valid ← 1. out_valid clears on out_valid && out_ready unless a new Output is accepted in the same cycle.
- FIFO:
  - o_cdb_valid = fifo_count ≠ 0; o_cdb = head entry.
  - Pop on o_cdb_valid && o_cdb_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Head and tail pointers wrap modulo RESULT_DEPTH.
- Results leave in acceptance order.
- Reset (nrst=1 at an edge) clears FIFO pointers and count, inflight, out_valid, err_opcode and err_addr. An in-flight load is discarded and never appears on the CDB. RAM contents are not reset.
- Reset values of outputs: o_cdb_valid=0, out_valid=0, err_opcode=0, err_addr=0, o_cdb=0, out_data=0. i_ready follows its equation with empty state.

## Timing
- Load latency: accepted at edge T → o_cdb_valid high in cycle T+2 (one cycle RAM, one cycle FIFO write).
- Load throughput: one per cycle sustained with o_cdb_ready=1 and RESULT_DEPTH ≥ 3.
- Store: RAM updated at the accepting edge; no output.
- Output: out_valid high the cycle after accept; holds until out_ready.
- Full credit: with count+inflight=RESULT_DEPTH, a load waits with i_ready=0 until a pop has retired, i.e. one cycle after the pop edge.
- o_cdb and out_data hold stable while their valid is high and ready is low.

## Test plan
- Store 0xDEADBEEF to 0x010 at cycle 0, load tag 5 from 0x010 at cycle 1 → o_cdb={5,0xDEADBEEF} valid at cycle 3.
- Eight back-to-back loads, tags 0–7, o_cdb_ready=1 → eight results in tag order on consecutive cycles, i_ready never low.
- o_cdb_ready=0, issue loads → exactly RESULT_DEPTH accepted, then i_ready=0; raise ready → results drain in order, loads resume.
- OUTPUT 0x41 then 0x42 with out_ready=0 → second held off (i_ready=0), out_data=0x41 stable; out_ready=1 → 0x41 then 0x42 delivered.
- Load from 1<<MEM_DEPTH_W → CDB data 0, err_addr=1. Opcode 0 → err_opcode=1, no CDB.
- Reset asserted the cycle after a load accept → no CDB result; all outputs at reset values next cycle.
